// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch/jump flush control; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_unit #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       ifid_opcode,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic [1:0]       idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    output logic             hazard_detected,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       uses_rs, uses_rt, lu;

    always_comb begin
        uses_rt = 1'b0;
        uses_rs = 1'b1;
        case (ifid_opcode)
            6'b000000, 6'b101011, 6'b101000,
            6'b101001, 6'b000100, 6'b000101: uses_rt = 1'b1;
            default:                         uses_rt = 1'b0;
        endcase
        case (ifid_opcode)
            6'b000010, 6'b000011, 6'b001111: uses_rs = 1'b0;
            default:                         uses_rs = 1'b1;
        endcase
    end

    assign lu = (idex_memread != 2'b00) && (idex_rt != 5'd0) &&
                ((uses_rs && (ifid_rs == idex_rt)) || (uses_rt && (ifid_rt == idex_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        hazard_detected = 1'b0;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        exmem_flush     = 1'b0;
        if (!rst_n) begin
            // Reset holds the front end and drains every stage register.
            state_d     = RUN;
            rem_d       = 2'd0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (branch_taken) begin
            state_d     = RUN;
            rem_d       = 2'd0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if ((state_q == STALL) || lu) begin
            hazard_detected = 1'b1;
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            idex_flush      = 1'b1;
            if (state_q == STALL) begin
                rem_d = rem_q - 2'd1;
                if (rem_q == 2'd1) begin
                    state_d = RUN;
                end
            end else if (LOAD_LAT > 1) begin
                state_d = STALL;
                rem_d   = 2'(LOAD_LAT - 1);
            end
        end else if (jump_id) begin
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // hazard_detected is only raised by a load-use stall; ifid_flush outside reset marks a branch or jump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard_detected && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scoreboard bench for hazard_unit at LOAD_LAT 1 and 3
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] NRM = 6'b011000;
    localparam logic [5:0] STL = 6'b100010;
    localparam logic [5:0] BRN = 6'b011111;
    localparam logic [5:0] JMP = 6'b011100;
    localparam logic [5:0] RST = 6'b000111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ifid_opcode;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic [1:0]  idex_memread;
    logic        branch_taken, jump_id;

    logic        hd1, pcw1, ifw1, iff1, idf1, exf1;
    logic        hd3, pcw3, ifw3, iff3, idf3, exf3;
    logic [15:0] sc1, fc1, sc3, fc3;
    logic [5:0]  v1, v3;

    typedef struct {
        string      tag;
        logic [5:0] e1;
        logic [5:0] e3;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_unit #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken), .jump_id(jump_id),
        .hazard_detected(hd1), .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(iff1),
        .idex_flush(idf1), .exmem_flush(exf1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_unit #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken), .jump_id(jump_id),
        .hazard_detected(hd3), .pc_write(pcw3), .ifid_write(ifw3), .ifid_flush(iff3),
        .idex_flush(idf3), .exmem_flush(exf3), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    assign v1 = {hd1, pcw1, ifw1, iff1, idf1, exf1};
    assign v3 = {hd3, pcw3, ifw3, iff3, idf3, exf3};

    task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] mr, input logic [4:0] xrt, input logic br, input logic j);
        ifid_opcode  = op;
        ifid_rs      = rs;
        ifid_rt      = rt;
        idex_memread = mr;
        idex_rt      = xrt;
        branch_taken = br;
        jump_id      = j;
    endtask

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            cmp({e.tag, "_lat1"}, {10'd0, v1}, {10'd0, e.e1});
            cmp({e.tag, "_lat3"}, {10'd0, v3}, {10'd0, e.e3});
        end
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] mr, input logic [4:0] xrt, input logic br, input logic j,
                        input logic [5:0] e1, input logic [5:0] e3);
        @(posedge clk);
        #1;
        set_in(op, rs, rt, mr, xrt, br, j);
        sb_q.push_back('{tag, e1, e3});
        @(negedge clk);
        pop_check();
    endtask

    task automatic check_cnt(input string tag, input int s1, input int f1, input int s3, input int f3);
        cmp({tag, "_stall1"}, sc1, PERF ? 16'(s1) : 16'd0);
        cmp({tag, "_flush1"}, fc1, PERF ? 16'(f1) : 16'd0);
        cmp({tag, "_stall3"}, sc3, PERF ? 16'(s3) : 16'd0);
        cmp({tag, "_flush3"}, fc3, PERF ? 16'(f3) : 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(6'b000000, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        sb_q.push_back('{"reset", RST, RST});
        pop_check();
        check_cnt("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0);

        step("idle",      6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0, NRM, NRM);
        step("lu_c1",     6'b000000, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0, STL, STL);
        step("lu_c2",     6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, NRM, STL);
        step("lu_c3",     6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, NRM, STL);
        step("lu_done",   6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, NRM, NRM);
        check_cnt("lu", 1, 0, 3, 0);

        step("lb_r0",     6'b000000, 5'd0, 5'd0, 2'b10, 5'd0, 1'b0, 1'b0, NRM, NRM);
        step("lui_rt",    6'b001111, 5'd7, 5'd5, 2'b01, 5'd5, 1'b0, 1'b0, NRM, NRM);

        step("br_stall",  6'b000000, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0, STL, STL);
        step("br_taken",  6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, BRN, BRN);
        step("br_after",  6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0, NRM, NRM);
        check_cnt("branch", 2, 1, 4, 1);

        step("jump",      6'b000010, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1, JMP, JMP);
        step("jump_lu",   6'b000000, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b1, STL, STL);
        step("jump_hold", 6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1, JMP, STL);
        step("jump_rel",  6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1, JMP, STL);
        step("jump_done", 6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0, NRM, NRM);
        check_cnt("jump", 3, 4, 7, 2);

        step("rst_lu",    6'b000000, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0, STL, STL);
        step("rst_mid",   6'b000000, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, NRM, STL);
        #2;
        rst_n = 1'b0;
        set_in(6'b000000, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0);
        #1;
        sb_q.push_back('{"rst_async", RST, RST});
        pop_check();
        check_cnt("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0);

        step("post_c1",   6'b101011, 5'd0, 5'd9, 2'b01, 5'd9, 1'b0, 1'b0, STL, STL);
        step("post_c2",   6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0, NRM, STL);
        step("post_c3",   6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0, NRM, STL);
        step("post_done", 6'b000000, 5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 1'b0, NRM, NRM);
        check_cnt("post", 1, 0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detection and flush controller for the 5-stage MIPS datapath. It produces the `hazard_detected` input consumed by the main decoder, along with the PC and IF/ID write enables and the per-stage flush strobes. Detection covers three cases:
- load-use data hazards, with a stall length set by parameter;
- taken branches resolved in MEM;
- jumps decoded in ID.

Optional saturating performance counters report stall and flush activity.

## Interface
Parameters:
- `LOAD_LAT`, default 1: stall cycles per load-use hazard; legal range 1..3.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ifid_opcode`  in  6: opcode of the instruction in ID.
- `ifid_rs`  in  5: rs field of the instruction in ID.
- `ifid_rt`  in  5: rt field of the instruction in ID.
- `idex_memread`  in  2: MemRead of the instruction in EX; any nonzero value is a load (lw/lb/lh).
- `idex_rt`  in  5: destination register of the load in EX.
- `branch_taken`  in  1: branch resolved taken in MEM.
- `jump_id`  in  1: Jump control bit of the instruction in ID.
- `hazard_detected`  out  1: to the decoder; holds the control outputs.
- `pc_write`  out  1: PC register enable.
- `ifid_write`  out  1: IF/ID register enable.
- `ifid_flush`  out  1: zero IF/ID on the next edge.
- `idex_flush`  out  1: zero ID/EX control on the next edge (inserts a bubble).
- `exmem_flush`  out  1: zero EX/MEM control on the next edge.
- `stall_cnt`  out  CNT_W: number of load-use stall cycles.
- `flush_cnt`  out  CNT_W: number of branch and jump flush events.

## Operation
Source-register use, decoded from `ifid_opcode`:
- `uses_rt` = R-type 000000, sw 101011, sb 101000, sh 101001, beq 000100, bne 000101.
- `uses_rs` = every opcode except j 000010, jal 000011, lui 001111.

Load-use condition:
- `lu` = (`idex_memread` != 0) and (`idex_rt` != 0) and ((`uses_rs` and `ifid_rs` == `idex_rt`) or (`uses_rt` and `ifid_rt` == `idex_rt`)).

FSM states: RUN, STALL. A 2-bit down-counter `rem` is used in STALL.

Output priority, evaluated every cycle from the current state and inputs:
1. `branch_taken`:
   - `ifid_flush` = `idex_flush` = `exmem_flush` = 1, `pc_write` = 1, `ifid_write` = 1, `hazard_detected` = 0.
   - Next state RUN, `rem` = 0. This aborts any stall in progress.
2. STALL state, or RUN with `lu`:
   - `pc_write` = 0, `ifid_write` = 0, `idex_flush` = 1, `hazard_detected` = 1.
   - In RUN with `lu` and `LOAD_LAT` > 1: next state STALL, `rem` = `LOAD_LAT` − 1.
   - In STALL: `rem` decrements each cycle. On the cycle where `rem` == 1 the next state is RUN. `lu` is not re-evaluated while in STALL.
3. `jump_id`: `ifid_flush` = 1. PC and IF/ID are enabled, so the PC loads the jump target.
4. Otherwise: `pc_write` = 1, `ifid_write` = 1, all flush strobes 0, `hazard_detected` = 0.

Behaviour for specific input combinations:
- **Jump during stall:** `jump_id` is ignored while a stall is active; the jump is seen again once the stall releases.
- **`LOAD_LAT` = 1:** the FSM never leaves RUN. The hazard clears naturally next cycle because the bubble now sits in EX.
- **Load to $0:** never stalls.

## Timing
- All outputs are combinational from the registered state and current inputs; zero-cycle latency.
- A load-use hazard costs exactly `LOAD_LAT` cycles with `pc_write` = 0.
- A taken branch costs 3 flushed slots. A jump costs 1 flushed slot.
- While `rst_n` = 0, outputs are forced as follows:
  - state RUN, `rem` = 0;
  - `hazard_detected` = 0, `pc_write` = 0, `ifid_write` = 0;
  - `ifid_flush` = `idex_flush` = `exmem_flush` = 1;
  - `stall_cnt` = `flush_cnt` = 0.
- Normal priority applies from the first edge after `rst_n` rises.
- Reset asserted mid-stall takes effect immediately (asynchronous) and discards the stall.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with `pc_write` = 0 caused by rule 2.
  - `flush_cnt` increments once per cycle in which rule 1 or rule 3 fires.
  - Both counters saturate at 2^CNT_W − 1.
- Macro undefined: both ports remain present and are tied to 0; no counter flops are instantiated.

## Test plan
- lw $5 in EX (`idex_memread` = 01, `idex_rt` = 5), add in ID with rs = 5, `LOAD_LAT` = 1 -> one cycle with `hazard_detected` = 1, `pc_write` = 0, `idex_flush` = 1; next cycle all normal; `stall_cnt` = 1.
- Same stimulus with `LOAD_LAT` = 3 -> 3 consecutive stall cycles, then RUN; `stall_cnt` = 3.
- lb to $0, or consumer opcode 001111 (lui) reading rt = `idex_rt` -> no stall.
- `branch_taken` = 1 on the 2nd cycle of a `LOAD_LAT` = 3 stall -> that cycle all three flushes = 1 and `pc_write` = 1; next cycle RUN with no stall; `flush_cnt` = 1.
- `jump_id` = 1 with no hazard -> `ifid_flush` = 1 for 1 cycle, `pc_write` = 1; `jump_id` = 1 concurrent with `lu` -> stall only, no `ifid_flush`.
- `rst_n` dropped mid-stall -> outputs immediately take their reset values, counters 0; after release, a fresh `lu` stalls for the full `LOAD_LAT`.
